// File: rtl/paint_pkg.sv
// paint_pkg: shared canvas geometry, colour type, palette and FSM encoding
package paint_pkg;
  localparam int CELLS_X = 160;
  localparam int CELLS_Y = 120;
  localparam int CELL_SHIFT = 2;
  typedef logic [2:0] color_t;
  localparam color_t COLOR_WHITE = 3'b111;
  typedef enum logic {IDLE, CLEAR} state_t;
  function automatic logic [23:0] expand(input color_t c);
    return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
  endfunction
  // row*160+col built from shifts so no multiplier is inferred
  function automatic logic [14:0] cell_addr(input logic [8:0] cx, input logic [8:0] cy);
    return 15'({cy, 7'b0}) + 15'({cy, 5'b0}) + 15'(cx);
  endfunction
endpackage

// File: rtl/canvas_ram.sv
// canvas_ram: simple dual-port block RAM, sync read returning old data on collision
module canvas_ram import paint_pkg::*; #(
  parameter int DEPTH = CELLS_X * CELLS_Y
) (
  input  logic        CLOCK_50,
  input  logic        we,
  input  logic [14:0] wr_addr,
  input  color_t      wr_data,
  input  logic [14:0] rd_addr,
  output color_t      rd_data
);
  color_t mem [DEPTH];
  // write port
  always_ff @(posedge CLOCK_50)
    if (we) mem[wr_addr] <= wr_data;
  // registered read port; same-edge write lands after this read
  always_ff @(posedge CLOCK_50)
    rd_data <= mem[rd_addr];
endmodule

// File: rtl/canvas_painter.sv
// canvas_painter: canvas pixel source with brush cursor, painting and canvas wipe
module canvas_painter #(
  parameter int CELLS_X = paint_pkg::CELLS_X,
  parameter int CELLS_Y = paint_pkg::CELLS_Y,
  parameter int CELL_SHIFT = paint_pkg::CELL_SHIFT
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [10:0] x_coord,
  input  logic [10:0] y_coord,
  input  logic        move_up,
  input  logic        move_down,
  input  logic        move_left,
  input  logic        move_right,
  input  logic        paint_en,
  input  logic [2:0]  color_sel,
  input  logic        clear,
  output logic [7:0]  top_R,
  output logic [7:0]  top_G,
  output logic [7:0]  top_B,
  output logic [7:0]  cursor_x,
  output logic [6:0]  cursor_y,
  output logic        busy
);
  import paint_pkg::*;
  localparam logic [14:0] LAST_ADDR = 15'(CELLS_X * CELLS_Y - 1);
  state_t state, state_nxt;
  logic [14:0] clr_addr, clr_nxt, rd_addr, wr_addr;
  logic [8:0] cx, cy;
  logic we, hit_q, off_q;
  color_t wr_data, rd_data, shown;
  assign cx = 9'(x_coord >> CELL_SHIFT);
  assign cy = 9'(y_coord >> CELL_SHIFT);
  assign rd_addr = cell_addr(cx, cy);
  assign busy = state == CLEAR;
  assign wr_addr = busy ? clr_addr : cell_addr({1'b0, cursor_x}, {2'b0, cursor_y});
  assign wr_data = busy ? COLOR_WHITE : color_sel;
  assign shown = hit_q ? ~rd_data : rd_data;
  canvas_ram u_ram (
    .CLOCK_50(CLOCK_50),
    .we(we),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );
  // FSM state and wipe address; reset starts a wipe from address 0
  always_ff @(posedge CLOCK_50)
    if (reset) begin
      state <= CLEAR;
      clr_addr <= '0;
    end else begin
      state <= state_nxt;
      clr_addr <= clr_nxt;
    end
  // wipe walks the whole canvas; painting and clear requests only act in IDLE
  always_comb begin
    state_nxt = state;
    clr_nxt = clr_addr;
    we = 1'b0;
    if (busy) begin
      we = 1'b1;
      clr_nxt = clr_addr + 1'b1;
      if (clr_addr == LAST_ADDR) state_nxt = IDLE;
    end else begin
      we = paint_en;
      if (clear) begin
        state_nxt = CLEAR;
        clr_nxt = '0;
      end
    end
  end
  // cursor moves saturate at the canvas edges; opposing pulses cancel
  always_ff @(posedge CLOCK_50)
    if (reset) begin
      cursor_x <= 8'(CELLS_X / 2);
      cursor_y <= 7'(CELLS_Y / 2);
    end else begin
      if (move_right && !move_left && cursor_x != 8'(CELLS_X - 1)) cursor_x <= cursor_x + 1'b1;
      else if (move_left && !move_right && cursor_x != '0) cursor_x <= cursor_x - 1'b1;
      if (move_down && !move_up && cursor_y != 7'(CELLS_Y - 1)) cursor_y <= cursor_y + 1'b1;
      else if (move_up && !move_down && cursor_y != '0) cursor_y <= cursor_y - 1'b1;
    end
  // align cursor hit and off-screen flag with the RAM read data
  always_ff @(posedge CLOCK_50) begin
    hit_q <= cx == {1'b0, cursor_x} && cy == {2'b0, cursor_y};
    off_q <= x_coord >= 11'(CELLS_X << CELL_SHIFT) || y_coord >= 11'(CELLS_Y << CELL_SHIFT);
  end
  // registered RGB, black outside the visible area
  always_ff @(posedge CLOCK_50)
    if (reset) {top_R, top_G, top_B} <= '0;
    else {top_R, top_G, top_B} <= off_q ? 24'h0 : expand(shown);
endmodule

// File: tb/tb_canvas_painter.sv
// tb_canvas_painter: directed self-checking bench for canvas_painter
module tb_canvas_painter;
  logic CLOCK_50 = 1'b0, reset = 1'b1;
  logic [10:0] x_coord = '0, y_coord = '0;
  logic move_up = 0, move_down = 0, move_left = 0, move_right = 0;
  logic paint_en = 0, clear = 0;
  logic [2:0] color_sel = '0;
  logic [7:0] top_R, top_G, top_B, cursor_x;
  logic [6:0] cursor_y;
  logic busy;
  int errors = 0, checks = 0, n = 0;

  canvas_painter dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .x_coord(x_coord), .y_coord(y_coord),
    .move_up(move_up), .move_down(move_down), .move_left(move_left), .move_right(move_right),
    .paint_en(paint_en), .color_sel(color_sel), .clear(clear),
    .top_R(top_R), .top_G(top_G), .top_B(top_B),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic step(input int c);
    repeat (c) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic [23:0] exp);
    x_coord = 11'(x);
    y_coord = 11'(y);
    step(2);
    chk(tag, {8'h0, top_R, top_G, top_B}, {8'h0, exp});
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 30000) begin
      step(1);
      cnt++;
    end
  endtask

  initial begin
    step(2);
    chk("reset_busy", 32'(busy), 1);
    chk("reset_cx", 32'(cursor_x), 80);
    chk("reset_cy", 32'(cursor_y), 60);
    chk("reset_rgb", {8'h0, top_R, top_G, top_B}, 0);
    reset = 0;
    wait_idle(n);
    chk("init_wipe_len", n, 19200);
    chk("init_busy_low", 32'(busy), 0);
    pix("white_0_0", 0, 0, 24'hFFFFFF);
    pix("white_639_479", 639, 479, 24'hFFFFFF);
    pix("cursor_on_white", 320, 240, 24'h000000);

    color_sel = 3'b100;
    paint_en = 1;
    step(1);
    paint_en = 0;
    move_right = 1;
    step(1);
    move_right = 0;
    chk("move_right_cx", 32'(cursor_x), 81);
    pix("red_320_240", 320, 240, 24'hFF0000);
    pix("red_323_243", 323, 243, 24'hFF0000);
    pix("cursor_324_240", 324, 240, 24'h000000);
    move_left = 1;
    step(1);
    move_left = 0;
    pix("cursor_on_red", 320, 240, 24'h00FFFF);

    for (int i = 0; i < 200; i++) begin
      move_left = 1;
      step(1);
      move_left = 0;
      step(1);
    end
    chk("sat_left", 32'(cursor_x), 0);
    for (int i = 0; i < 130; i++) begin
      move_down = 1;
      step(1);
      move_down = 0;
      step(1);
    end
    chk("sat_down", 32'(cursor_y), 119);
    move_up = 1;
    move_down = 1;
    move_left = 1;
    move_right = 1;
    step(1);
    move_down = 0;
    move_left = 0;
    move_right = 0;
    move_up = 0;
    chk("cancel_y", 32'(cursor_y), 119);
    chk("cancel_x", 32'(cursor_x), 0);
    move_right = 1;
    move_up = 1;
    step(1);
    move_right = 0;
    move_up = 0;
    chk("diag_x", 32'(cursor_x), 1);
    chk("diag_y", 32'(cursor_y), 118);

    pix("off_x700", 700, 10, 24'h000000);
    pix("off_y480", 639, 480, 24'h000000);

    paint_en = 1;
    step(1);
    paint_en = 0;
    move_right = 1;
    step(1);
    move_right = 0;
    pix("red_4_472", 4, 472, 24'hFF0000);
    clear = 1;
    step(1);
    clear = 0;
    chk("clear_busy", 32'(busy), 1);
    step(99);
    clear = 1;
    paint_en = 1;
    step(1);
    clear = 0;
    paint_en = 0;
    wait_idle(n);
    chk("clear_len_ignore_2nd", n + 100, 19200);
    pix("cleared_4_472", 4, 472, 24'hFFFFFF);
    pix("cleared_320_240", 320, 240, 24'hFFFFFF);

    clear = 1;
    step(1);
    clear = 0;
    step(5000);
    chk("midclear_busy", 32'(busy), 1);
    reset = 1;
    step(1);
    reset = 0;
    chk("midreset_busy", 32'(busy), 1);
    chk("midreset_cx", 32'(cursor_x), 80);
    wait_idle(n);
    chk("midreset_wipe_len", n, 19200);

    color_sel = 3'b000;
    paint_en = 1;
    clear = 1;
    step(1);
    clear = 0;
    wait_idle(n);
    paint_en = 0;
    chk("paint_clear_len", n, 19200);
    move_right = 1;
    step(1);
    move_right = 0;
    pix("paint_ignored_320", 320, 240, 24'hFFFFFF);
    pix("cursor_324_after", 324, 240, 24'h000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
